// File: rtl/midi_pkg.sv
// midi_pkg: constants, parse-state and emitter-state types, and helper
// functions shared by the MIDI input parser and its byte FIFO.
// No ports. This package does not depend on any build macro.
package midi_pkg;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_POLY_AT  = 4'hA;
  localparam logic [3:0] ST_CTRL     = 4'hB;
  localparam logic [3:0] ST_PROG     = 4'hC;
  localparam logic [3:0] ST_CHAN_AT  = 4'hD;
  localparam logic [3:0] ST_PITCH    = 4'hE;
  localparam logic [3:0] ST_SYS      = 4'hF;

  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;

  typedef enum logic [1:0] {P_IDLE, P_D1, P_D2, P_SYSEX} parse_t;
  typedef enum logic [1:0] {E_IDLE, E_UPD, E_HIGH, E_LOW} emit_t;

  // Number of data bytes that follow a status byte. The result is only
  // meaningful for status bytes (bit 7 set).
  function automatic logic [1:0] data_len(input logic [7:0] status);
    logic [1:0] len;
    case (status[7:4])
      ST_PROG, ST_CHAN_AT: len = 2'd1;
      ST_SYS: begin
        case (status[3:0])
          4'h1, 4'h3: len = 2'd1;
          4'h2:       len = 2'd2;
          default:    len = 2'd0;
        endcase
      end
      default: len = 2'd2;
    endcase
    return len;
  endfunction

  function automatic logic is_realtime(input logic [7:0] b);
    return (b[7:3] == 5'b11111);
  endfunction

endpackage

// File: rtl/midi_byte_fifo.sv
// midi_byte_fifo: synchronous FIFO holding received bytes with their
// framing-error flag until the parser can take them.
// Ports:
//   CLOCK_25  in   clock
//   iRST_N    in   async active-low reset
//   wr_en     in   write request
//   wr_data   in   {err, byte}
//   rd_en     in   pop request (ignored when empty)
//   rd_data   out  head entry, valid while !empty
//   full      out  all DEPTH entries used
//   empty     out  no entries
//   ovf       out  one-cycle pulse: write discarded because full
module midi_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             CLOCK_25,
  input  logic             iRST_N,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign do_rd = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO
  // is still accepted then.
  assign do_wr = wr_en && (!full || do_rd);
  assign ovf   = wr_en && full && !do_rd;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge CLOCK_25) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/midi_in_parser.sv
// midi_in_parser: byte-level MIDI stream parser between the UART receiver
// and midi_decoder. Tracks running status, numbers data bytes within a
// message, filters realtime bytes and presents each kept byte as
// {cur_status, midi_bytes, databyte} qualified by a byteready pulse.
// midi_decoder samples on the falling edge of byteready.
// Build macro: MIDI_RT_OUT_EN adds the rt_valid/rt_byte realtime outputs.
// Ports:
//   CLOCK_25    in   system clock
//   iRST_N      in   async active-low reset
//   rx_valid    in   one-cycle strobe, rx_data/rx_err valid
//   rx_data     in   received byte
//   rx_err      in   framing error on this byte
//   byteready   out  high BR_HIGH cycles per emitted byte
//   cur_status  out  status byte in force (0x00 = none)
//   midi_bytes  out  data byte index in message, 0 = status byte
//   databyte    out  emitted byte value
//   drop_cnt    out  saturating count of orphan data bytes dropped
//   fifo_ovf    out  sticky FIFO overflow flag
//   rt_valid    out  (MIDI_RT_OUT_EN) strobe when a realtime byte is popped
//   rt_byte     out  (MIDI_RT_OUT_EN) last realtime byte
//
// Emitter states:
//   E_IDLE | pop and classify the FIFO head when available
//   E_UPD  | load output fields from the classified byte
//   E_HIGH | byteready high, BR_HIGH cycles
//   E_LOW  | byteready low, BR_LOW cycles, fields held
// Parse states:
//   P_IDLE  | no status in force, data bytes are orphans
//   P_D1    | expecting first data byte
//   P_D2    | expecting second data byte
//   P_SYSEX | inside a system exclusive message
module midi_in_parser import midi_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int BR_HIGH    = 4,
  parameter int BR_LOW     = 4
) (
  input  logic       CLOCK_25,
  input  logic       iRST_N,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  output logic       byteready,
  output logic [7:0] cur_status,
  output logic [7:0] midi_bytes,
  output logic [7:0] databyte,
  output logic [7:0] drop_cnt,
  output logic       fifo_ovf
`ifdef MIDI_RT_OUT_EN
  ,
  output logic       rt_valid,
  output logic [7:0] rt_byte
`endif
);

  logic [8:0]  head;
  logic [7:0]  b;
  logic        f_full;
  logic        f_empty;
  logic        f_ovf;
  logic        pop;

  emit_t       e_state, e_next;
  parse_t      parse_q, parse_d;
  logic [7:0]  run_st_q, run_st_d;
  logic [7:0]  sx_cnt_q, sx_cnt_d;
  logic [15:0] tmr_q;
  logic        tmr_tc;

  logic        c_emit, c_clr, c_drop, c_err;
  logic [7:0]  c_st, c_idx;

  logic [7:0]  pend_st, pend_idx, pend_byte;
  logic        pend_clr;

  midi_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9)) u_fifo (
    .CLOCK_25 (CLOCK_25),
    .iRST_N   (iRST_N),
    .wr_en    (rx_valid),
    .wr_data  ({rx_err, rx_data}),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (f_full),
    .empty    (f_empty),
    .ovf      (f_ovf)
  );

  assign b         = head[7:0];
  assign tmr_tc    = (tmr_q == 16'd0);
  assign byteready = (e_state == E_HIGH);

  // Classification of the FIFO head; only committed on a pop.
  always_comb begin
    parse_d  = parse_q;
    run_st_d = run_st_q;
    sx_cnt_d = sx_cnt_q;
    c_emit   = 1'b0;
    c_clr    = 1'b0;
    c_drop   = 1'b0;
    c_err    = 1'b0;
    c_st     = run_st_q;
    c_idx    = 8'd0;
    if (head[8]) begin
      c_err    = 1'b1;
      run_st_d = 8'h00;
      parse_d  = P_IDLE;
    end else if (is_realtime(b)) begin
      // realtime bytes are transparent to parsing
    end else if (b[7]) begin
      c_emit   = 1'b1;
      c_st     = b;
      run_st_d = b;
      if (b == SYSEX_START) begin
        parse_d  = P_SYSEX;
        sx_cnt_d = 8'd0;
      end else if (b == SYSEX_END || (b[7:4] == ST_SYS && data_len(b) == 2'd0)) begin
        // emitted with its own status, cleared once the pulse is over
        c_clr    = 1'b1;
        run_st_d = 8'h00;
        parse_d  = P_IDLE;
      end else begin
        parse_d = P_D1;
      end
    end else begin
      case (parse_q)
        P_D1: begin
          c_emit = 1'b1;
          c_idx  = 8'd1;
          if (data_len(run_st_q) == 2'd2) begin
            parse_d = P_D2;
          end else if (run_st_q[7:4] != ST_SYS) begin
            parse_d = P_D1;
          end else begin
            c_clr    = 1'b1;
            run_st_d = 8'h00;
            parse_d  = P_IDLE;
          end
        end
        P_D2: begin
          c_emit = 1'b1;
          c_idx  = 8'd2;
          if (run_st_q[7:4] != ST_SYS) begin
            parse_d = P_D1;
          end else begin
            c_clr    = 1'b1;
            run_st_d = 8'h00;
            parse_d  = P_IDLE;
          end
        end
        P_SYSEX: begin
          c_emit = 1'b1;
          if (sx_cnt_q != 8'hFF) sx_cnt_d = sx_cnt_q + 8'd1;
          c_idx = sx_cnt_d;
        end
        default: c_drop = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) e_state <= E_IDLE;
    else         e_state <= e_next;
  end

  always_comb begin
    e_next = e_state;
    pop    = 1'b0;
    unique case (e_state)
      E_IDLE: begin
        if (!f_empty) begin
          pop = 1'b1;
          if (c_emit) e_next = E_UPD;
        end
      end
      E_UPD:   e_next = E_HIGH;
      E_HIGH:  if (tmr_tc) e_next = E_LOW;
      E_LOW:   if (tmr_tc) e_next = E_IDLE;
      default: e_next = E_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      tmr_q <= 16'd0;
    end else if (e_state == E_UPD) begin
      tmr_q <= 16'(BR_HIGH - 1);
    end else if (e_state == E_HIGH && tmr_tc) begin
      tmr_q <= 16'(BR_LOW - 1);
    end else if (!tmr_tc) begin
      tmr_q <= tmr_q - 16'd1;
    end
  end

  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      parse_q    <= P_IDLE;
      run_st_q   <= 8'h00;
      sx_cnt_q   <= 8'h00;
      pend_st    <= 8'h00;
      pend_idx   <= 8'h00;
      pend_byte  <= 8'h00;
      pend_clr   <= 1'b0;
      cur_status <= 8'h00;
      midi_bytes <= 8'h00;
      databyte   <= 8'h00;
      drop_cnt   <= 8'h00;
      fifo_ovf   <= 1'b0;
    end else begin
      if (f_ovf) fifo_ovf <= 1'b1;
      if (pop) begin
        parse_q  <= parse_d;
        run_st_q <= run_st_d;
        sx_cnt_q <= sx_cnt_d;
        if (c_emit) begin
          pend_st   <= c_st;
          pend_idx  <= c_idx;
          pend_byte <= b;
          pend_clr  <= c_clr;
        end
        // emitter is idle here, so clearing the visible status is safe
        if (c_err) cur_status <= 8'h00;
        if (c_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
      if (e_state == E_UPD) begin
        cur_status <= pend_st;
        midi_bytes <= pend_idx;
        databyte   <= pend_byte;
      end
      // message-ending bytes keep their status visible through the falling
      // edge of byteready, then drop it
      if (e_state == E_LOW && tmr_tc && pend_clr) cur_status <= 8'h00;
    end
  end

`ifdef MIDI_RT_OUT_EN
  logic [7:0] rt_byte_q;

  assign rt_valid = pop && !head[8] && is_realtime(b);
  assign rt_byte  = rt_valid ? b : rt_byte_q;

  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N)       rt_byte_q <= 8'h00;
    else if (rt_valid) rt_byte_q <= b;
  end
`endif

endmodule

// File: tb/tb_midi_in_parser.sv
// Directed bench for midi_in_parser: hand-computed emissions captured at
// each falling edge of byteready, plus status/drop/overflow checks.
module tb_midi_in_parser;
  localparam int FIFO_DEPTH = 4;
  localparam int BR_HIGH    = 4;
  localparam int BR_LOW     = 4;

  logic       CLOCK_25 = 1'b0;
  logic       iRST_N   = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_err   = 1'b0;
  logic       byteready;
  logic [7:0] cur_status, midi_bytes, databyte, drop_cnt;
  logic       fifo_ovf;
`ifdef MIDI_RT_OUT_EN
  logic       rt_valid;
  logic [7:0] rt_byte;
  int         rt_cnt = 0;
  logic [7:0] rt_last = 8'h00;
`endif

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;
  int t_wr = 0;
  logic [23:0] emits[$];
  int widths[$];
  int rise_cyc[$];
  logic br_prev = 1'b0;
  int hi_cnt = 0;
  int rd_idx = 0;
  int base;
  logic [7:0] burst [6];

  midi_in_parser #(.FIFO_DEPTH(FIFO_DEPTH), .BR_HIGH(BR_HIGH), .BR_LOW(BR_LOW)) dut (
    .CLOCK_25   (CLOCK_25),
    .iRST_N     (iRST_N),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_err     (rx_err),
    .byteready  (byteready),
    .cur_status (cur_status),
    .midi_bytes (midi_bytes),
    .databyte   (databyte),
    .drop_cnt   (drop_cnt),
    .fifo_ovf   (fifo_ovf)
`ifdef MIDI_RT_OUT_EN
    ,
    .rt_valid   (rt_valid),
    .rt_byte    (rt_byte)
`endif
  );

  always #20 CLOCK_25 = ~CLOCK_25;
  always @(posedge CLOCK_25) cyc <= cyc + 1;

  // fields are recorded at the first low sample after byteready falls
  always @(negedge CLOCK_25) begin
    if (byteready) begin
      if (!br_prev) begin
        hi_cnt = 0;
        rise_cyc.push_back(cyc);
      end
      hi_cnt++;
    end else if (br_prev) begin
      emits.push_back({cur_status, midi_bytes, databyte});
      widths.push_back(hi_cnt);
    end
    br_prev = byteready;
`ifdef MIDI_RT_OUT_EN
    if (rt_valid) begin
      rt_cnt++;
      rt_last = rt_byte;
    end
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] v, input logic e);
    @(posedge CLOCK_25); #1;
    rx_valid = 1'b1; rx_data = v; rx_err = e; t_wr = cyc;
    @(posedge CLOCK_25); #1;
    rx_valid = 1'b0; rx_err = 1'b0;
    repeat (12) @(posedge CLOCK_25);
  endtask

  // wait (bounded) until n emissions exist in total, then let the emitter settle
  task automatic wait_emits(input string tag, input int n);
    int budget = 600;
    while (emits.size() < n && budget > 0) begin
      @(negedge CLOCK_25);
      budget--;
    end
    repeat (BR_HIGH + BR_LOW + 6) @(negedge CLOCK_25);
    chk({tag, "_count"}, emits.size(), n);
  endtask

  task automatic expect_emit(input string tag, input logic [7:0] st, input logic [7:0] idx,
                             input logic [7:0] by);
    if (rd_idx < emits.size()) begin
      chk(tag, emits[rd_idx], {st, idx, by});
      chk({tag, "_width"}, widths[rd_idx], BR_HIGH);
    end else begin
      chk({tag, "_missing"}, emits.size(), rd_idx + 1);
    end
    rd_idx++;
  endtask

  task automatic do_reset();
    @(posedge CLOCK_25); #1;
    iRST_N = 1'b0;
    repeat (3) @(posedge CLOCK_25);
    #1 iRST_N = 1'b1;
  endtask

  initial begin
    burst[0] = 8'hB0; burst[1] = 8'h01; burst[2] = 8'h02;
    burst[3] = 8'h03; burst[4] = 8'h04; burst[5] = 8'h05;

    repeat (3) @(posedge CLOCK_25);
    #1 iRST_N = 1'b1;
    @(negedge CLOCK_25);
    chk("rst_byteready", byteready, 1'b0);
    chk("rst_cur_status", cur_status, 8'h00);
    chk("rst_midi_bytes", midi_bytes, 8'h00);
    chk("rst_databyte", databyte, 8'h00);
    chk("rst_drop_cnt", drop_cnt, 8'h00);
    chk("rst_fifo_ovf", fifo_ovf, 1'b0);

    // 1: note on
    base = emits.size();
    send(8'h90, 1'b0);
    if (rise_cyc.size() > 0) chk("t1_latency", rise_cyc[0] - t_wr, 3);
    else chk("t1_latency_norise", rise_cyc.size(), 1);
    send(8'h3C, 1'b0);
    send(8'h64, 1'b0);
    wait_emits("t1", base + 3);
    expect_emit("t1_status", 8'h90, 8'd0, 8'h90);
    expect_emit("t1_d1", 8'h90, 8'd1, 8'h3C);
    expect_emit("t1_d2", 8'h90, 8'd2, 8'h64);

    // 2: running status
    base = emits.size();
    send(8'h3E, 1'b0);
    send(8'h40, 1'b0);
    wait_emits("t2", base + 2);
    expect_emit("t2_d1", 8'h90, 8'd1, 8'h3E);
    expect_emit("t2_d2", 8'h90, 8'd2, 8'h40);

    // 3: realtime byte in the middle of a message
    base = emits.size();
    send(8'h90, 1'b0);
    send(8'hF8, 1'b0);
    send(8'h3C, 1'b0);
    send(8'h64, 1'b0);
    wait_emits("t3", base + 3);
    expect_emit("t3_status", 8'h90, 8'd0, 8'h90);
    expect_emit("t3_d1", 8'h90, 8'd1, 8'h3C);
    expect_emit("t3_d2", 8'h90, 8'd2, 8'h64);
`ifdef MIDI_RT_OUT_EN
    chk("t3_rt_cnt", rt_cnt, 1);
    chk("t3_rt_byte", rt_last, 8'hF8);
`endif

    // 4: sysex with a realtime byte inside
    base = emits.size();
    send(8'hF0, 1'b0);
    send(8'h7D, 1'b0);
    send(8'hF8, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'hF7, 1'b0);
    wait_emits("t4", base + 6);
    expect_emit("t4_f0", 8'hF0, 8'd0, 8'hF0);
    expect_emit("t4_b1", 8'hF0, 8'd1, 8'h7D);
    expect_emit("t4_b2", 8'hF0, 8'd2, 8'h01);
    expect_emit("t4_b3", 8'hF0, 8'd3, 8'h02);
    expect_emit("t4_b4", 8'hF0, 8'd4, 8'h03);
    expect_emit("t4_f7", 8'hF7, 8'd0, 8'hF7);
    chk("t4_status_after", cur_status, 8'h00);

    // 5: orphans after reset, then one-data-byte running status
    do_reset();
    rd_idx = emits.size();
    @(negedge CLOCK_25);
    chk("t5_rst_cur_status", cur_status, 8'h00);
    chk("t5_rst_databyte", databyte, 8'h00);
    base = emits.size();
    send(8'h3C, 1'b0);
    send(8'h64, 1'b0);
    repeat (20) @(negedge CLOCK_25);
    chk("t5_no_emit", emits.size(), base);
    chk("t5_drop_cnt", drop_cnt, 8'd2);
    send(8'hC5, 1'b0);
    send(8'h07, 1'b0);
    send(8'h08, 1'b0);
    wait_emits("t5", base + 3);
    expect_emit("t5_status", 8'hC5, 8'd0, 8'hC5);
    expect_emit("t5_d1a", 8'hC5, 8'd1, 8'h07);
    expect_emit("t5_d1b", 8'hC5, 8'd1, 8'h08);

    // 6a: framing error aborts the message, next data byte is an orphan
    base = emits.size();
    send(8'h90, 1'b0);
    send(8'h3C, 1'b1);
    send(8'h64, 1'b0);
    wait_emits("t6a", base + 1);
    expect_emit("t6a_status", 8'h90, 8'd0, 8'h90);
    chk("t6a_cur_status", cur_status, 8'h00);
    chk("t6a_drop_cnt", drop_cnt, 8'd3);

    // system common: F2 completes and clears, F6 has no data
    base = emits.size();
    send(8'hF2, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h05, 1'b0);
    send(8'hF6, 1'b0);
    wait_emits("t6s", base + 4);
    expect_emit("t6s_f2", 8'hF2, 8'd0, 8'hF2);
    expect_emit("t6s_d1", 8'hF2, 8'd1, 8'h01);
    expect_emit("t6s_d2", 8'hF2, 8'd2, 8'h02);
    expect_emit("t6s_f6", 8'hF6, 8'd0, 8'hF6);
    chk("t6s_cur_status", cur_status, 8'h00);
    chk("t6s_drop_cnt", drop_cnt, 8'd4);
    chk("t6s_no_ovf", fifo_ovf, 1'b0);

    // 6b: back-to-back burst of FIFO_DEPTH+2 bytes; head is popped in time
    base = emits.size();
    @(posedge CLOCK_25); #1;
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      rx_valid = 1'b1;
      rx_data  = burst[i];
      @(posedge CLOCK_25); #1;
    end
    rx_valid = 1'b0;
    wait_emits("t6b", base + FIFO_DEPTH + 1);
    repeat (40) @(negedge CLOCK_25);
    chk("t6b_final_count", emits.size(), base + FIFO_DEPTH + 1);
    chk("t6b_ovf", fifo_ovf, 1'b1);
    expect_emit("t6b_e0", 8'hB0, 8'd0, 8'hB0);
    expect_emit("t6b_e1", 8'hB0, 8'd1, 8'h01);
    expect_emit("t6b_e2", 8'hB0, 8'd2, 8'h02);
    expect_emit("t6b_e3", 8'hB0, 8'd1, 8'h03);
    expect_emit("t6b_e4", 8'hB0, 8'd2, 8'h04);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
